// File: rtl/load_store_unit.sv
// Load/store unit between MEM stage and data cache: sub-word extract/merge via read-modify-write.
// Latency 3 cycles for load/sw, 6 for sb/sh on hits; stalls on c_rdy=0 indefinitely, misaligned/illegal completes in 1.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic [31:0] stall_cnt,
  output logic        c_en,
  output logic        c_r0w1,
  output logic [31:0] c_addr,
  output logic [31:0] c_din,
  input  logic        c_rdy,
  input  logic [31:0] c_dout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_buf;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_stall_cnt;

  logic        w_legal;
  logic        w_misal;
  logic        w_bad;
  logic        w_sw;
  logic        w_enter_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                   (op == 3'b100) || (op == 3'b101);
  assign w_misal = ((op[1:0] == 2'b01) && addr[0]) ||
                   ((op == 3'b010) && (addr[1:0] != 2'b00));
  assign w_bad   = ~w_legal | w_misal;
  assign w_sw    = we & (op == 3'b010);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_bad)     w_next = S_DONE;
          else if (w_sw) w_next = S_WR;
          else           w_next = S_RD;
        end
      end
      S_RD: begin
        if (c_rdy) w_next = we ? S_MERGE : S_DONE;
      end
      S_MERGE: w_next = S_WR;
      S_WR: begin
        if (c_rdy) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    c_en   = 1'b0;
    c_r0w1 = 1'b0;
    c_addr = 32'd0;
    c_din  = 32'd0;
    done   = 1'b0;
    case (r_state)
      S_RD: begin
        c_en   = 1'b1;
        c_addr = {addr[31:2], 2'b00};
      end
      S_MERGE: c_din = w_merged;
      S_WR: begin
        c_en   = 1'b1;
        c_r0w1 = 1'b1;
        c_addr = {addr[31:2], 2'b00};
        c_din  = w_sw ? wdata : r_buf;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Lane extraction works straight off c_dout so the result is ready on entry to DONE
  always_comb begin
    w_byte = c_dout[7:0];
    case (addr[1:0])
      2'd0: w_byte = c_dout[7:0];
      2'd1: w_byte = c_dout[15:8];
      2'd2: w_byte = c_dout[23:16];
      2'd3: w_byte = c_dout[31:24];
      default: w_byte = c_dout[7:0];
    endcase
  end

  assign w_half = addr[1] ? c_dout[31:16] : c_dout[15:0];

  always_comb begin
    w_load = 32'd0;
    case (op)
      3'b000: w_load = {{24{w_byte[7]}}, w_byte};
      3'b001: w_load = {{16{w_half[15]}}, w_half};
      3'b010: w_load = c_dout;
      3'b100: w_load = {24'd0, w_byte};
      3'b101: w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  always_comb begin
    w_merged = r_buf;
    if (op[1:0] == 2'b00) begin
      case (addr[1:0])
        2'd0: w_merged[7:0]   = wdata[7:0];
        2'd1: w_merged[15:8]  = wdata[7:0];
        2'd2: w_merged[23:16] = wdata[7:0];
        2'd3: w_merged[31:24] = wdata[7:0];
        default: ;
      endcase
    end else if (addr[1]) begin
      w_merged[31:16] = wdata[15:0];
    end else begin
      w_merged[15:0]  = wdata[15:0];
    end
  end

  assign w_enter_done = (r_state != S_DONE) && (w_next == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf   <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == S_RD) && c_rdy) r_buf <= c_dout;
      if (r_state == S_MERGE)         r_buf <= w_merged;
      // Only the RD->DONE path is a load; IDLE->DONE is an error, WR->DONE a store
      if (w_enter_done) begin
        r_err   <= (r_state == S_IDLE);
        r_rdata <= (r_state == S_RD) ? w_load : 32'd0;
      end
    end
  end

  assign stall = req & ~done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_stall_cnt <= 32'd0;
    else if (stall && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign rdata     = r_rdata;
  assign err       = r_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word cache (registered ready, optional extra latency).
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;
  logic [31:0] stall_cnt;
  logic        c_en;
  logic        c_r0w1;
  logic [31:0] c_addr;
  logic [31:0] c_din;
  logic        c_rdy;
  logic [31:0] c_dout;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .op(op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .stall(stall), .stall_cnt(stall_cnt),
    .c_en(c_en), .c_r0w1(c_r0w1), .c_addr(c_addr), .c_din(c_din),
    .c_rdy(c_rdy), .c_dout(c_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int          wait_cnt;
  int          extra_lat = 0;
  logic        pl_vld = 1'b0;
  logic [31:0] pl_a = 32'd0;
  logic [31:0] pl_d = 32'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_rdy    <= 1'b0;
      c_dout   <= 32'd0;
      wait_cnt <= 0;
    end else begin
      if (pl_vld) mem[pl_a[7:2]] <= pl_d;
      if (c_en && !c_rdy) begin
        if (wait_cnt < extra_lat) begin
          wait_cnt <= wait_cnt + 1;
        end else begin
          wait_cnt <= 0;
          c_rdy    <= 1'b1;
          if (c_r0w1) mem[c_addr[7:2]] <= c_din;
          else        c_dout <= mem[c_addr[7:2]];
        end
      end else begin
        c_rdy <= 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  int          a_done_cyc;
  int          a_rdy_cyc;
  logic [31:0] a_mask;
  logic [31:0] a_rdata;
  logic [31:0] a_wdin;
  logic [31:0] a_delta;
  logic        a_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_vld = 1'b1;
    pl_a   = a;
    pl_d   = d;
    @(posedge clk); #1;
    pl_vld = 1'b0;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the edge ending DONE.
  task automatic access(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    int          cyc;
    logic [31:0] base;
    req = 1'b1; we = w; op = o; addr = a; wdata = d;
    base = stall_cnt;
    cyc = 0;
    a_mask = 32'd0; a_wdin = 32'd0; a_rdy_cyc = -1; a_done_cyc = -1;
    forever begin
      @(negedge clk);
      if (c_en && cyc < 32) a_mask[cyc] = 1'b1;
      if (c_rdy) a_rdy_cyc = cyc;
      if (c_en && c_r0w1) a_wdin = c_din;
      if (done) begin
        a_done_cyc = cyc;
        a_rdata    = rdata;
        a_err      = err;
        a_delta    = stall_cnt - base;
        break;
      end
      if (cyc >= 100) begin
        checks++;
        errors++;
        $error("FAIL timeout waiting for done addr=0x%08h", a);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    int pulses;
    #12;
    chk("rst_c_en", {31'd0, c_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_c_addr", c_addr, 32'd0);
    chk("rst_c_din", c_din, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    preload(32'h10, 32'h80000010);
    preload(32'h24, 32'h11F2A380);
    preload(32'h40, 32'hAABBCCDD);
    preload(32'h50, 32'h01234567);

    access(1'b0, 3'b010, 32'h10, 32'd0);
    chk("lw_done_cyc", a_done_cyc, 32'd3);
    chk("lw_cen_mask", a_mask, 32'h6);
    chk("lw_rdata", a_rdata, 32'h80000010);
    chk("lw_err", {31'd0, a_err}, 32'd0);
    chk("lw_stall_delta", a_delta, 32'd3);

    access(1'b0, 3'b000, 32'h25, 32'd0);
    chk("lb_25", a_rdata, 32'hFFFFFFA3);
    access(1'b0, 3'b100, 32'h26, 32'd0);
    chk("lbu_26", a_rdata, 32'h000000F2);
    access(1'b0, 3'b001, 32'h26, 32'd0);
    chk("lh_26", a_rdata, 32'h000011F2);
    access(1'b0, 3'b101, 32'h24, 32'd0);
    chk("lhu_24", a_rdata, 32'h0000A380);
    access(1'b0, 3'b001, 32'h24, 32'd0);
    chk("lh_24", a_rdata, 32'hFFFFA380);

    access(1'b1, 3'b000, 32'h41, 32'h00000012);
    chk("sb_done_cyc", a_done_cyc, 32'd6);
    chk("sb_cen_mask", a_mask, 32'h36);
    chk("sb_c_din", a_wdin, 32'hAABB12DD);
    chk("sb_rdata", a_rdata, 32'd0);
    chk("sb_err", {31'd0, a_err}, 32'd0);
    access(1'b0, 3'b010, 32'h40, 32'd0);
    chk("lw_after_sb", a_rdata, 32'hAABB12DD);

    access(1'b1, 3'b010, 32'h44, 32'hCAFEF00D);
    chk("sw_done_cyc", a_done_cyc, 32'd3);
    chk("sw_c_din", a_wdin, 32'hCAFEF00D);
    access(1'b1, 3'b001, 32'h46, 32'h00005A5A);
    chk("sh_done_cyc", a_done_cyc, 32'd6);
    chk("sh_c_din", a_wdin, 32'h5A5AF00D);
    access(1'b0, 3'b010, 32'h44, 32'd0);
    chk("lw_after_sh", a_rdata, 32'h5A5AF00D);
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_hold", rdata, 32'h5A5AF00D);

    access(1'b0, 3'b010, 32'h42, 32'd0);
    chk("mis_lw_done_cyc", a_done_cyc, 32'd1);
    chk("mis_lw_err", {31'd0, a_err}, 32'd1);
    chk("mis_lw_rdata", a_rdata, 32'd0);
    chk("mis_lw_cen_mask", a_mask, 32'd0);
    chk("mis_lw_stall_delta", a_delta, 32'd1);
    access(1'b1, 3'b001, 32'h43, 32'h0000BEEF);
    chk("mis_sh_done_cyc", a_done_cyc, 32'd1);
    chk("mis_sh_err", {31'd0, a_err}, 32'd1);
    chk("mis_sh_cen_mask", a_mask, 32'd0);
    access(1'b0, 3'b011, 32'h40, 32'd0);
    chk("illegal_op_err", {31'd0, a_err}, 32'd1);
    chk("illegal_op_cen_mask", a_mask, 32'd0);
    access(1'b0, 3'b010, 32'h10, 32'd0);
    chk("err_clears", {31'd0, a_err}, 32'd0);

    extra_lat = 5;
    access(1'b0, 3'b010, 32'h40, 32'd0);
    extra_lat = 0;
    chk("miss_done_cyc", a_done_cyc, 32'd8);
    chk("miss_rdy_cyc", a_rdy_cyc, 32'd7);
    chk("miss_stall_delta", a_delta, 32'd8);
    chk("miss_rdata", a_rdata, 32'hAABB12DD);

    extra_lat = 3;
    req = 1'b1; we = 1'b1; op = 3'b010; addr = 32'h50; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_c_en", {31'd0, c_en}, 32'd1);
    chk("wr_c_r0w1", {31'd0, c_r0w1}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_c_en", {31'd0, c_en}, 32'd0);
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_c_addr", c_addr, 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    extra_lat = 0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || c_en) pulses++;
    end
    chk("midrst_no_activity", pulses, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 3'b010, 32'h50, 32'd0);
    chk("postrst_done_cyc", a_done_cyc, 32'd3);
    chk("postrst_rdata", a_rdata, 32'h01234567);
    chk("postrst_stall_cnt", stall_cnt, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
